// File: rtl/ifft_sdf_stage_type2.sv
// Radix-2 single-path delay-feedback butterfly stage, inverse direction.
// Pairs samples DEPTH apart through a delay buffer. It emits the scaled sum
// at once. The scaled difference (rotated by +j in the upper half of the
// half-frame) is emitted during the next frame's first half.
module ifft_sdf_stage_type2 #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] real_in,
    input  logic signed [DATA_WIDTH-1:0] imag_in,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] real_out,
    output logic signed [DATA_WIDTH-1:0] imag_out
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // Two guard bits: one for the add/sub growth, one for the rounding +1.
    localparam int EW = DW + 2;

    localparam logic signed [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};

    // Counter, flags and registered outputs
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 primed_q, primed_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] re_out_q, re_out_d;
    logic signed [DW-1:0] im_out_q, im_out_d;

    // Delay buffer (no reset: every entry is rewritten before it is emitted)
    logic signed [DW-1:0] buf_re_q [DEPTH];
    logic signed [DW-1:0] buf_im_q [DEPTH];
    logic                 buf_we;
    logic signed [DW-1:0] buf_re_d, buf_im_d;

    // Datapath nets
    logic                 accept;
    logic                 phase;
    logic [AW-1:0]        k;
    logic                 upper_half;
    logic signed [DW-1:0] a_re, a_im;
    logic signed [EW-1:0] sum_re_w, sum_im_w, dif_re_w, dif_im_w;
    logic signed [DW:0]   sum_re_h, sum_im_h, dif_re_h, dif_im_h;
    logic signed [DW-1:0] sum_re, sum_im;
    logic signed [DW-1:0] dif_re, dif_im;
    logic signed [DW-1:0] rot_re, rot_im;

    function automatic logic signed [EW-1:0] sext(input logic signed [DW-1:0] v);
        return {{2{v[DW-1]}}, v};
    endfunction

    // (v + 1) >>> 1 : halve with round-half-up
    function automatic logic signed [DW:0] halve(input logic signed [EW-1:0] v);
        logic signed [EW-1:0] t;
        logic signed [EW-1:0] s;
        t = v + {{(EW-1){1'b0}}, 1'b1};
        s = t >>> 1;
        return s[DW:0];
    endfunction

    // Only +2^(W-1) can exceed the output range; it is pattern 01xx..x at DW+1 bits
    function automatic logic signed [DW-1:0] clamp_pos(input logic signed [DW:0] v);
        logic signed [DW-1:0] r;
        if (v[DW:DW-1] == 2'b01) begin
            r = MAX_POS;
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction

    assign accept     = enable & in_valid;
    assign phase      = cnt_q[AW];
    assign k          = cnt_q[AW-1:0];
    assign upper_half = k[AW-1];
    assign a_re       = buf_re_q[k];
    assign a_im       = buf_im_q[k];

    // Butterfly arithmetic: widened add/sub, rounding halve, clamp, +j rotation
    always_comb begin
        sum_re_w = sext(a_re) + sext(real_in);
        sum_im_w = sext(a_im) + sext(imag_in);
        dif_re_w = sext(a_re) - sext(real_in);
        dif_im_w = sext(a_im) - sext(imag_in);

        sum_re_h = halve(sum_re_w);
        sum_im_h = halve(sum_im_w);
        dif_re_h = halve(dif_re_w);
        dif_im_h = halve(dif_im_w);

        sum_re   = sum_re_h[DW-1:0];
        sum_im   = sum_im_h[DW-1:0];
        dif_re   = clamp_pos(dif_re_h);
        dif_im   = clamp_pos(dif_im_h);

        // Clamped difference is symmetric, so negation cannot overflow
        if (upper_half) begin
            rot_re = -dif_im;
            rot_im = dif_re;
        end else begin
            rot_re = dif_re;
            rot_im = dif_im;
        end
    end

    // Next-state: counter, primed flag, output register and buffer write
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = out_valid_q;
        re_out_d    = re_out_q;
        im_out_d    = im_out_q;
        buf_we      = 1'b0;
        buf_re_d    = real_in;
        buf_im_d    = imag_in;

        if (enable) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
                cnt_d  = cnt_q + CW'(1);
                buf_we = 1'b1;
                if (&cnt_q) begin
                    primed_d = 1'b1;
                end
                if (!phase) begin
                    // First half: drain the previous frame's difference, store raw input
                    out_valid_d = primed_q;
                    if (primed_q) begin
                        re_out_d = a_re;
                        im_out_d = a_im;
                    end
                    buf_re_d = real_in;
                    buf_im_d = imag_in;
                end else begin
                    // Second half: emit sum now, park rotated difference for later
                    out_valid_d = 1'b1;
                    re_out_d    = sum_re;
                    im_out_d    = sum_im;
                    buf_re_d    = rot_re;
                    buf_im_d    = rot_im;
                end
            end
        end
    end

    // Control and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            re_out_q    <= '0;
            im_out_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            re_out_q    <= re_out_d;
            im_out_q    <= im_out_d;
        end
    end

    // Delay buffer write; the read of entry k above sees the old contents
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_re_q[k] <= buf_re_d;
            buf_im_q[k] <= buf_im_d;
        end
    end

    assign out_valid = out_valid_q;
    assign real_out  = re_out_q;
    assign imag_out  = im_out_q;

endmodule

// File: tb/tb_ifft_sdf_stage_type2.sv
// Self-checking bench for ifft_sdf_stage_type2 (DATA_WIDTH=16, DEPTH=4).
module tb_ifft_sdf_stage_type2;

    localparam int DW = 16;
    localparam int D  = 4;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b1;
    logic                 enable   = 1'b0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] real_in  = '0;
    logic signed [DW-1:0] imag_in  = '0;
    logic                 out_valid;
    logic signed [DW-1:0] real_out;
    logic signed [DW-1:0] imag_out;

    int errors = 0;
    int checks = 0;

    // Expected output scoreboard
    logic signed [DW-1:0] q_re [$];
    logic signed [DW-1:0] q_im [$];
    logic signed [DW-1:0] last_re = '0;
    logic signed [DW-1:0] last_im = '0;
    logic signed [DW-1:0] er, ei;

    // Reference model state
    int  n_m       = 0;
    bit  primed_m  = 1'b0;
    bit  will_emit = 1'b0;
    bit  use_model = 1'b0;
    bit  emit_q    = 1'b0;
    bit  new_q     = 1'b0;
    int  first_re [D];
    int  first_im [D];
    int  pend_re  [D];
    int  pend_im  [D];

    always #5 clk = ~clk;

    ifft_sdf_stage_type2 #(
        .DATA_WIDTH(DW),
        .DEPTH     (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_valid (in_valid),
        .real_in  (real_in),
        .imag_in  (imag_in),
        .out_valid(out_valid),
        .real_out (real_out),
        .imag_out (imag_out)
    );

    // Expected out_valid after each edge, and whether a fresh sample appears
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_q <= 1'b0;
            new_q  <= 1'b0;
        end else if (enable) begin
            emit_q <= will_emit;
            new_q  <= will_emit;
        end else begin
            new_q  <= 1'b0;
        end
    end

    // Monitor on the falling edge
    always @(negedge clk) begin
        checks++;
        assert (out_valid === emit_q) else begin
            errors++;
            $error("FAIL out_valid observed=%0b expected=%0b", out_valid, emit_q);
        end
        if (new_q) begin
            checks++;
            assert (q_re.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output observed=(%0d,%0d) expected=none", real_out, imag_out);
            end
            if (q_re.size() != 0) begin
                er = q_re.pop_front();
                ei = q_im.pop_front();
                checks++;
                assert (real_out === er && imag_out === ei) else begin
                    errors++;
                    $error("FAIL out_data observed=(%0d,%0d) expected=(%0d,%0d)", real_out, imag_out, er, ei);
                end
                last_re = er;
                last_im = ei;
            end
        end else begin
            checks++;
            assert (real_out === last_re && imag_out === last_im) else begin
                errors++;
                $error("FAIL out_hold observed=(%0d,%0d) expected=(%0d,%0d)", real_out, imag_out, last_re, last_im);
            end
        end
    end

    function automatic int scale(input int v);
        int t;
        t = v + 1;
        return t >>> 1;
    endfunction

    function automatic int scale_d(input int v);
        int r;
        r = scale(v);
        if (r == (1 << (DW - 1))) r = r - 1;
        return r;
    endfunction

    task automatic expect_out(input int re, input int im);
        q_re.push_back(re[DW-1:0]);
        q_im.push_back(im[DW-1:0]);
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic step(input bit en, input bit vld, input int re, input int im);
        int k;
        int dr;
        int di;
        enable   = en;
        in_valid = vld;
        real_in  = re[DW-1:0];
        imag_in  = im[DW-1:0];
        if (en && vld) begin
            k = n_m % D;
            will_emit = (n_m >= D) || primed_m;
            if (use_model) begin
                if (n_m < D) begin
                    if (primed_m) expect_out(pend_re[k], pend_im[k]);
                    first_re[k] = re;
                    first_im[k] = im;
                end else begin
                    expect_out(scale(first_re[k] + re), scale(first_im[k] + im));
                    dr = scale_d(first_re[k] - re);
                    di = scale_d(first_im[k] - im);
                    if (k >= D / 2) begin
                        pend_re[k] = -di;
                        pend_im[k] = dr;
                    end else begin
                        pend_re[k] = dr;
                        pend_im[k] = di;
                    end
                end
            end
            n_m++;
            if (n_m == 2 * D) begin
                n_m      = 0;
                primed_m = 1'b1;
            end
        end else if (en) begin
            will_emit = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        assert (out_valid === 1'b0 && real_out === '0 && imag_out === '0) else begin
            errors++;
            $error("FAIL async_reset observed=(%0b,%0d,%0d) expected=(0,0,0)", out_valid, real_out, imag_out);
        end
        q_re.delete();
        q_im.delete();
        last_re   = '0;
        last_im   = '0;
        n_m       = 0;
        primed_m  = 1'b0;
        will_emit = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string tag);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        checks++;
        assert (q_re.size() == 0) else begin
            errors++;
            $error("FAIL %s_pending observed=%0d expected=0", tag, q_re.size());
        end
    endtask

    task automatic ramp_frame();
        for (int i = 1; i <= 2 * D; i++) step(1'b1, 1'b1, i, 0);
    endtask

    task automatic zero_frame();
        for (int i = 0; i < 2 * D; i++) step(1'b1, 1'b1, 0, 0);
    endtask

    task automatic expect_basic();
        expect_out(3, 0);  expect_out(4, 0);  expect_out(5, 0);  expect_out(6, 0);
        expect_out(-2, 0); expect_out(-2, 0); expect_out(0, -2); expect_out(0, -2);
        for (int i = 0; i < D; i++) expect_out(0, 0);
    endtask

    logic signed [DW-1:0] rr, ri;

    initial begin
        #2;
        // Reset mid-stream, then no output for the first DEPTH inputs
        do_reset();
        use_model = 1'b1;
        ramp_frame();
        step(1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b1, 0, 0);
        do_reset();
        for (int i = 1; i <= D; i++) step(1'b1, 1'b1, i, 0);
        drain_check("post_reset");

        // Basic frame
        use_model = 1'b0;
        do_reset();
        expect_basic();
        ramp_frame();
        zero_frame();
        drain_check("basic");

        // Saturation and rounding boundaries
        do_reset();
        expect_out(0, 0);          expect_out(-32768, 32767);
        expect_out(0, 0);          expect_out(32767, -32768);
        expect_out(32767, -32767); expect_out(0, 0);
        expect_out(32767, 32767);  expect_out(0, 0);
        for (int i = 0; i < D; i++) expect_out(0, 0);
        step(1'b1, 1'b1, 32767, -32768);
        step(1'b1, 1'b1, -32768, 32767);
        step(1'b1, 1'b1, 32767, -32768);
        step(1'b1, 1'b1, 32767, -32768);
        step(1'b1, 1'b1, -32768, 32767);
        step(1'b1, 1'b1, -32768, 32767);
        step(1'b1, 1'b1, -32768, 32767);
        step(1'b1, 1'b1, 32767, -32768);
        zero_frame();
        drain_check("saturation");

        // in_valid toggling every cycle
        do_reset();
        expect_basic();
        for (int i = 1; i <= 2 * D; i++) begin
            step(1'b1, 1'b1, i, 0);
            step(1'b1, 1'b0, 77, 77);
        end
        for (int i = 0; i < 2 * D; i++) begin
            step(1'b1, 1'b1, 0, 0);
            step(1'b1, 1'b0, -5, 9);
        end
        drain_check("gaps");

        // enable low for 3 cycles while an output is being presented
        do_reset();
        expect_basic();
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, i, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 99, -99);
        for (int i = 7; i <= 8; i++) step(1'b1, 1'b1, i, 0);
        zero_frame();
        drain_check("enable");

        // Reset mid-frame, then a clean frame
        do_reset();
        expect_out(3, 0);
        expect_out(4, 0);
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, i, 0);
        step(1'b1, 1'b0, 0, 0);
        do_reset();
        expect_basic();
        ramp_frame();
        zero_frame();
        drain_check("reset_mid");

        // Back-to-back frames
        do_reset();
        expect_out(3, 0);  expect_out(4, 0);  expect_out(5, 0);  expect_out(6, 0);
        expect_out(-2, 0); expect_out(-2, 0); expect_out(0, -2); expect_out(0, -2);
        for (int i = 0; i < D; i++) expect_out(100, -100);
        for (int i = 0; i < 2 * D; i++) expect_out(0, 0);
        ramp_frame();
        for (int i = 0; i < 2 * D; i++) step(1'b1, 1'b1, 100, -100);
        zero_frame();
        drain_check("b2b");

        // Random frames with random gaps against the reference model
        use_model = 1'b1;
        do_reset();
        for (int i = 0; i < 4 * D; i++) begin
            rr = DW'($urandom);
            ri = DW'($urandom);
            step(1'b1, 1'b1, int'(rr), int'(ri));
            if ($urandom_range(0, 2) == 0) step(1'b1, 1'b0, 0, 0);
        end
        zero_frame();
        drain_check("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
